// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared registered ALU.
// Traps illegal codes and divide-by-zero locally and returns one tagged response per operation.
module alu_arbiter #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_func,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_func,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic [4:0]   rsp_flags,
    output logic         rsp_err,
    output logic [3:0]   alu_func,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,
    input  logic         alu_carry,
    input  logic         alu_arith,
    input  logic         alu_logic,
    input  logic         alu_cmp,
    input  logic         alu_shift
);

    typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

    state_e       state_q, state_d;
    logic         ptr_q;
    logic         grant_id;
    logic         accept;
    logic [3:0]   sel_func;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic         trap_div;
    logic         trap_ill;
    logic         trap;

    // The pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ptr_q;
        end
    end

    assign accept   = rst_n && (state_q == StIdle) && (req0_valid || req1_valid);
    assign sel_func = grant_id ? req1_func : req0_func;
    assign sel_a    = grant_id ? req1_a : req0_a;
    assign sel_b    = grant_id ? req1_b : req0_b;
    assign trap_div = (sel_func == 4'b0011) && (sel_b == '0);
    assign trap_ill = (sel_func[3:1] == 3'b111);
    assign trap     = trap_div || trap_ill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = trap ? StResp : StExec;
                end
            end
            StExec: state_d = StCapt;
            StCapt: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        rsp_valid  = (state_q == StResp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            alu_func   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            if (accept) begin
                ptr_q  <= ~grant_id;
                rsp_id <= grant_id;
                if (trap) begin
                    rsp_result <= trap_div ? {N{1'b1}} : '0;
                    rsp_flags  <= '0;
                    rsp_err    <= 1'b1;
                end else begin
                    alu_func <= sel_func;
                    alu_a    <= sel_a;
                    alu_b    <= sel_b;
                end
            end
            if (state_q == StCapt) begin
                rsp_result <= alu_out;
                rsp_flags  <= {alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift};
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plant, per-requester drivers, transaction-level
// reference model with a response scoreboard checked by a negedge monitor.
module tb_alu_arbiter;
    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_func, req1_func;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [N-1:0] rsp_result;
    logic [4:0]   rsp_flags;
    logic [3:0]   alu_func;
    logic [N-1:0] alu_a, alu_b, alu_out;
    logic         alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_carry(alu_carry), .alu_arith(alu_arith), .alu_logic(alu_logic),
        .alu_cmp(alu_cmp), .alu_shift(alu_shift)
    );

    typedef struct packed {
        logic [3:0]   func;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   gap;
    } op_t;

    typedef struct {
        logic         id;
        logic [N-1:0] result;
        logic [4:0]   flags;
        logic         err;
        int           due;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   acc0 = 0, acc1 = 0, mptr = 0, clean = 1;
    logic [3:0]   m_func = '0;
    logic [N-1:0] m_a = '0, m_b = '0;

    // ALU behaviour: {carry, arith, logic, cmp, shift, result}
    function automatic logic [N+4:0] alu_ref(input logic [3:0] f, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        logic [N:0]   wide;
        logic [N-1:0] r;
        logic         c;
        c = 1'b0;
        r = '0;
        case (f)
            4'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[N-1:0]; c = wide[N]; end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a * b;
            4'd3: r = (b == '0) ? '0 : a / b;
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~a;
            4'd8: r = a << b[3:0];
            4'd9: r = a >> b[3:0];
            4'd10: r = a << 1;
            4'd11: r = a >> 1;
            4'd12: r[0] = (a == b);
            4'd13: r[0] = (a > b);
            default: r = '0;
        endcase
        return {c, (f <= 4'd3), (f >= 4'd4 && f <= 4'd7), (f >= 4'd12 && f <= 4'd13),
                (f >= 4'd8 && f <= 4'd11), r};
    endfunction

    always_ff @(posedge clk) begin
        {alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift, alu_out} <=
            alu_ref(alu_func, alu_a, alu_b);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_accept(input logic id, input logic [3:0] f, input logic [N-1:0] a,
                             input logic [N-1:0] b);
        exp_t         e;
        logic [N+4:0] r;
        r    = alu_ref(f, a, b);
        e.id = id;
        if (f >= 4'd14) begin
            e.result = '0; e.flags = '0; e.err = 1'b1; e.due = cyc + 1;
        end else if (f == 4'd3 && b == '0) begin
            e.result = '1; e.flags = '0; e.err = 1'b1; e.due = cyc + 1;
        end else begin
            e.result = r[N-1:0]; e.flags = r[N+4:N]; e.err = 1'b0; e.due = cyc + 3;
            m_func = f; m_a = a; m_b = b;
        end
        sb.push_back(e);
        mptr  = ~id;
        clean = 0;
        if (id) acc1 = 1; else acc0 = 1;
    endtask

    // Monitor: the arbiter serves one transaction at a time, round-robin on ties.
    always @(negedge clk) begin
        logic busy, e0, e1, ev;
        cyc++;
        busy = (sb.size() > 0);
        e0 = rst_n && !busy && req0_valid && (!req1_valid || !mptr);
        e1 = rst_n && !busy && req1_valid && (!req0_valid || mptr);
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("alu_func", alu_func, m_func);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        ev = 1'b0;
        if (busy) ev = (cyc >= sb[0].due);
        check("rsp_valid", rsp_valid, ev);
        if (ev) begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_result", rsp_result, sb[0].result);
            check("rsp_flags", rsp_flags, sb[0].flags);
            check("rsp_err", rsp_err, sb[0].err);
        end else if (clean) begin
            check("idle rsp_id", rsp_id, 0);
            check("idle rsp_result", rsp_result, 0);
            check("idle rsp_flags", rsp_flags, 0);
            check("idle rsp_err", rsp_err, 0);
        end
        if (!rst_n) begin
            sb.delete();
            mptr = 0; clean = 1; m_func = '0; m_a = '0; m_b = '0;
        end else begin
            if (ev && rsp_valid && rsp_ready) void'(sb.pop_front());
            if (req0_valid && req0_ready) do_accept(1'b0, req0_func, req0_a, req0_b);
            if (req1_valid && req1_ready) do_accept(1'b1, req1_func, req1_a, req1_b);
        end
    end

    // Drivers: hold each op until accepted, honouring its leading idle gap.
    initial begin
        op_t h;
        req0_valid = 0; req0_func = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_func = '0; req1_a = '0; req1_b = '0;
        forever begin
            @(posedge clk); #1;
            if (acc0) begin void'(q0.pop_front()); acc0 = 0; end
            if (acc1) begin void'(q1.pop_front()); acc1 = 0; end
            req0_valid = 0;
            if (q0.size() > 0) begin
                h = q0[0];
                if (h.gap != 0) begin
                    h.gap = h.gap - 4'd1; q0[0] = h;
                end else begin
                    req0_valid = 1; req0_func = h.func; req0_a = h.a; req0_b = h.b;
                end
            end
            req1_valid = 0;
            if (q1.size() > 0) begin
                h = q1[0];
                if (h.gap != 0) begin
                    h.gap = h.gap - 4'd1; q1[0] = h;
                end else begin
                    req1_valid = 1; req1_func = h.func; req1_a = h.a; req1_b = h.b;
                end
            end
        end
    end

    task automatic push(input logic id, input logic [3:0] f, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [3:0] gap);
        op_t o;
        o = '{func: f, a: a, b: b, gap: gap};
        if (id) q1.push_back(o); else q0.push_back(o);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || acc0 || acc1) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL drain: %0d ops still outstanding, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int n;
        rst_n = 0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        push(0, 4'd0, 16'h0010, 16'h000A, 0);
        drain();
        push(1, 4'd0, 16'hFFFD, 16'h0003, 0);
        drain();

        // Simultaneous after reset, then continuous contention
        reset_pulse();
        push(0, 4'd1, 16'd16, 16'd10, 0);
        push(1, 4'd2, 16'd16, 16'd10, 0);
        push(0, 4'd5, 16'h00F0, 16'h0F00, 0);
        push(1, 4'd6, 16'h1234, 16'h00FF, 0);
        push(0, 4'd8, 16'h0001, 16'h0004, 0);
        push(1, 4'd13, 16'h0009, 16'h0003, 0);
        drain();

        // Back-pressure with a competing request pending
        rsp_ready = 0;
        push(0, 4'd4, 16'hF0F0, 16'h3C3C, 0);
        push(1, 4'd7, 16'h00FF, 16'h0000, 1);
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        tests++;
        if (n >= 20) begin fails++; $display("FAIL bp wait: rsp_valid 0, expected 1"); end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1;
        drain();

        // Trapped operations
        push(0, 4'd3, 16'd200, 16'd0, 0);
        push(1, 4'b1110, 16'h1234, 16'h5678, 0);
        push(0, 4'b1111, 16'h0001, 16'h0001, 2);
        push(1, 4'd3, 16'd200, 16'd7, 0);
        drain();

        // Reset while the operation sits in CAPT
        push(1, 4'd0, 16'h1111, 16'h2222, 0);
        n = 0;
        while (sb.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1 push(1, 4'd6, 16'h0011, 16'h1111, 0);
        drain();

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if ((r == 0 ? q0.size() : q1.size()) < 2 && $urandom_range(0, 3) == 0) begin
                    push(r[0], 4'($urandom_range(0, 15)), 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                         4'($urandom_range(0, 2)));
                end
            end
        end
        rsp_ready = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared `Parameterized_ALU`. It accepts operation requests over valid/ready handshakes and drives the ALU's registered inputs. It waits out the ALU's one-cycle registered latency, then returns the result and flags on a single response channel tagged with the requester id. Illegal function codes and divide-by-zero are trapped locally and never reach the ALU.

## Interface
- `N`, 16, operand/result width; matches the ALU's `n`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_func` in 4: ALU function code.
- `req0_a` in N: operand A.
- `req0_b` in N: operand B.
- `req1_valid`, `req1_ready`, `req1_func`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_result` out N: ALU result.
- `rsp_flags` out 5: {Carry, Arith, Logic, CMP, Shift}.
- `rsp_err` out 1: operation trapped, not executed.
- `alu_func` out 4: drives ALU `ALU_Func`.
- `alu_a` out N: drives ALU `A`.
- `alu_b` out N: drives ALU `B`.
- `alu_out` in N: from ALU `ALU_out`.
- `alu_carry`, `alu_arith`, `alu_logic`, `alu_cmp`, `alu_shift` in 1 each: ALU flags.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - If any `reqX_valid` is high, grant one requester and assert its `reqX_ready` for that cycle only.
  - `reqX_ready` is combinational from valid, state and the priority pointer.
  - At most one ready is high per cycle.
  - On acceptance, latch func/a/b and the id.
- Legal operation (func 0000–1101, and not DIV with B==0):
  - `alu_func`/`alu_a`/`alu_b` registers load the payload.
  - Transition IDLE→EXEC→CAPT→RESP.
- Trapped operation (func 1110/1111, or func 0011 with B==0):
  - `alu_*` registers keep their previous values.
  - `rsp_result` = {N{1'b1}} for DIV/0, 0 for an illegal code.
  - `rsp_flags` = 0, `rsp_err` = 1.
  - Transition IDLE→RESP.
- EXEC: ALU inputs are stable; the ALU registers its output at the end of this cycle.
- CAPT: latch `alu_out` into `rsp_result`, the five flags into `rsp_flags`, and set `rsp_err` = 0.
- RESP:
  - `rsp_valid` = 1, all `rsp_*` held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
- Round-robin:
  - A 1-bit pointer names the preferred requester.
  - If both are valid, grant the pointer's requester.
  - After any grant, the pointer becomes the other requester.
- Requesters must hold valid and payload stable until ready. Behaviour on withdrawal before acceptance is undefined.
- `alu_*` hold their last issued values between operations.

## Timing
- Reset (`rst_n` low at a rising edge), from any state:
  - state=IDLE, pointer=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0, `rsp_err`=0.
  - `alu_func`=0, `alu_a`=0, `alu_b`=0.
  - `req0_ready`/`req1_ready` are forced to 0 while `rst_n` is low.
  - An in-flight operation is discarded with no response.
- Legal op latency:
  - Accept in cycle C0.
  - `alu_*` valid in C1 (EXEC).
  - ALU output valid in C2 (CAPT).
  - `rsp_valid` high from C3.
- Trapped op latency: accept in C0, `rsp_valid` high in C1.
- Throughput with `rsp_ready` held high: one legal op per 4 cycles, one trapped op per 2 cycles.
- Back-pressure: RESP holds indefinitely. No new acceptance occurs until the response handshake completes.
- Response fired and a request pending in the same cycle: the new request is accepted in the following IDLE cycle, not the same cycle.

## Test plan
- **Basic ADD:** req0 ADD 0x0010 + 0x000A → `rsp_valid` 3 cycles after accept, `rsp_id`=0, `rsp_result`=0x001A, Carry=0, `rsp_err`=0.
- **ADD with carry:** req1 ADD 0xFFFD + 0x0003 → `rsp_id`=1, `rsp_result`=0x0000, Carry=1.
- **Simultaneous requests after reset:** req0 SUB 16−10 and req1 MUL 16×10 both valid → first response id 0 with 0x0006, second id 1 with 0x00A0. Keep both valid continuously afterwards; grants must alternate 0,1,0,1.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles while a response is pending → `rsp_*` stable, both readies 0. Release → exactly one handshake, then return to IDLE.
- **Trapped operations:**
  - req0 DIV A=200, B=0 → `rsp_valid` 1 cycle after accept, `rsp_err`=1, result 0xFFFF, `alu_func` unchanged.
  - func 4'b1110 → `rsp_err`=1, result 0x0000.
- **Reset mid-operation:** assert `rst_n`=0 in CAPT → no response, all outputs at reset values. After release, a req1 XOR 0x0011^0x1111 yields 0x1100 with id 1.
